// File: rtl/grid_buffer.sv
// grid_buffer: double-banked GRID_W x GRID_H bit grid with engine/back-bank
// writes, user edits and display reads on the front bank, a bank swap and a
// sequential clear of both banks.
// Optional feature macro: POPULATION_COUNT_EN (live-cell counter latched on swap).
module grid_buffer #(
  parameter int unsigned GRID_W = 80,
  parameter int unsigned GRID_H = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  read_x,
  input  logic [5:0]  read_y,
  output logic        cell_state,
  input  logic [6:0]  write_x,
  input  logic [5:0]  write_y,
  input  logic        write_value,
  input  logic        write_enable,
  input  logic [6:0]  disp_x,
  input  logic [5:0]  disp_y,
  output logic        disp_cell,
  input  logic        edit_en,
  input  logic [6:0]  edit_x,
  input  logic [5:0]  edit_y,
  input  logic        edit_value,
  input  logic        swap_req,
  output logic        swap_done,
  input  logic        clear_req,
  output logic        busy,
  output logic        front_sel,
  output logic [12:0] population
);

  localparam int unsigned CELLS = GRID_W * GRID_H;
  localparam int unsigned AW    = 13;
  localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

  typedef enum logic [1:0] {IDLE, CLEARING, SWAP} state_t;

  state_t          state_q;
  logic            front_sel_q;
  logic            swap_done_q;
  logic            pend_q;
  logic [AW-1:0]   clr_addr_q;
  logic            disp_cell_q;
  logic            bank_q [2][CELLS];

  // True when a coordinate lies inside the grid
  function automatic logic in_grid(input logic [6:0] x, input logic [5:0] y);
    return (32'(x) < GRID_W) && (32'(y) < GRID_H);
  endfunction

  // Linear address y*GRID_W + x
  function automatic logic [AW-1:0] addr_of(input logic [6:0] x, input logic [5:0] y);
    return AW'(y) * AW'(GRID_W) + AW'(x);
  endfunction

  logic          rd_ok_c, wr_ok_c, ed_ok_c, dp_ok_c, swap_go_c;
  logic [AW-1:0] raddr_c, waddr_c, eaddr_c, daddr_c;

  // Address decode, access qualification and swap-entry detection
  always_comb begin
    rd_ok_c   = in_grid(read_x, read_y);
    dp_ok_c   = in_grid(disp_x, disp_y);
    wr_ok_c   = (state_q == IDLE) && write_enable && in_grid(write_x, write_y);
    ed_ok_c   = (state_q == IDLE) && edit_en && in_grid(edit_x, edit_y);
    raddr_c   = addr_of(read_x, read_y);
    waddr_c   = addr_of(write_x, write_y);
    eaddr_c   = addr_of(edit_x, edit_y);
    daddr_c   = addr_of(disp_x, disp_y);
    swap_go_c = ((state_q == IDLE) && swap_req && !clear_req) ||
                ((state_q == CLEARING) && (clr_addr_q == LAST_ADDR) && (pend_q || swap_req));
  end

  // Control FSM: clear sequencing, swap pending and front bank selection
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEARING;
      front_sel_q <= 1'b0;
      swap_done_q <= 1'b0;
      pend_q      <= 1'b0;
      clr_addr_q  <= '0;
    end else begin
      swap_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_q    <= CLEARING;
            clr_addr_q <= '0;
            pend_q     <= swap_req;
          end else if (swap_req) begin
            state_q     <= SWAP;
            front_sel_q <= ~front_sel_q;
            swap_done_q <= 1'b1;
          end
        end
        CLEARING: begin
          if (clr_addr_q == LAST_ADDR) begin
            pend_q <= 1'b0;
            if (pend_q || swap_req) begin
              state_q     <= SWAP;
              front_sel_q <= ~front_sel_q;
              swap_done_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            clr_addr_q <= clr_addr_q + AW'(1);
            if (swap_req) pend_q <= 1'b1;
          end
        end
        SWAP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bank storage: clear both banks, or take engine write and user edit
  always_ff @(posedge clk) begin
    if (!rst && (state_q == CLEARING)) begin
      bank_q[0][clr_addr_q] <= 1'b0;
      bank_q[1][clr_addr_q] <= 1'b0;
    end else if (!rst) begin
      if (wr_ok_c) bank_q[~front_sel_q][waddr_c] <= write_value;
      if (ed_ok_c) bank_q[front_sel_q][eaddr_c]  <= edit_value;
    end
  end

  // Registered display read of the front bank
  always_ff @(posedge clk) begin
    if (rst) disp_cell_q <= 1'b0;
    else     disp_cell_q <= dp_ok_c ? bank_q[front_sel_q][daddr_c] : 1'b0;
  end

  assign cell_state = rd_ok_c ? bank_q[front_sel_q][raddr_c] : 1'b0;
  assign disp_cell  = disp_cell_q;
  assign swap_done  = swap_done_q;
  assign front_sel  = front_sel_q;
  assign busy       = (state_q != IDLE);

`ifdef POPULATION_COUNT_EN
  logic [12:0] pop_cnt_q;
  logic [12:0] population_q;
  logic [12:0] pop_next_c;

  assign pop_next_c = pop_cnt_q + 13'(wr_ok_c & write_value);

  // Live-write counter, latched into population on swap entry
  always_ff @(posedge clk) begin
    if (rst || (state_q == CLEARING)) begin
      pop_cnt_q    <= '0;
      population_q <= '0;
    end else if (swap_go_c) begin
      population_q <= pop_next_c;
      pop_cnt_q    <= '0;
    end else begin
      pop_cnt_q <= pop_next_c;
    end
  end

  assign population = population_q;
`else
  logic unused_swap_go;
  assign unused_swap_go = swap_go_c;
  assign population     = '0;
`endif

endmodule

// File: tb/tb_grid_buffer.sv
// Directed bench for grid_buffer with a scoreboard for the registered display read.
module tb_grid_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  read_x, write_x, disp_x, edit_x;
  logic [5:0]  read_y, write_y, disp_y, edit_y;
  logic        cell_state, write_value, write_enable, disp_cell;
  logic        edit_en, edit_value, swap_req, swap_done, clear_req, busy, front_sel;
  logic [12:0] population;

  int n_total = 0;
  int n_pass  = 0;
  bit disp_sb [$];

  grid_buffer dut (
    .clk(clk), .rst(rst),
    .read_x(read_x), .read_y(read_y), .cell_state(cell_state),
    .write_x(write_x), .write_y(write_y), .write_value(write_value), .write_enable(write_enable),
    .disp_x(disp_x), .disp_y(disp_y), .disp_cell(disp_cell),
    .edit_en(edit_en), .edit_x(edit_x), .edit_y(edit_y), .edit_value(edit_value),
    .swap_req(swap_req), .swap_done(swap_done), .clear_req(clear_req),
    .busy(busy), .front_sel(front_sel), .population(population)
  );

  always #5 clk = ~clk;

`ifdef POPULATION_COUNT_EN
  localparam int POP_EXP = 3;
`else
  localparam int POP_EXP = 0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic read_chk(input string tag, input int x, input int y, input logic exp);
    read_x = 7'(x);
    read_y = 6'(y);
    #1;
    check(tag, 32'(cell_state), 32'(exp));
  endtask

  // Present a display address, expect the value one edge later
  task automatic disp_probe(input string tag, input int x, input int y, input bit exp);
    bit e;
    disp_x = 7'(x);
    disp_y = 6'(y);
    disp_sb.push_back(exp);
    tick();
    e = disp_sb.pop_front();
    check(tag, 32'(disp_cell), 32'(e));
  endtask

  task automatic eng_write(input int x, input int y, input logic v);
    write_enable = 1'b1;
    write_x = 7'(x);
    write_y = 6'(y);
    write_value = v;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic edit(input int x, input int y, input logic v);
    edit_en = 1'b1;
    edit_x = 7'(x);
    edit_y = 6'(y);
    edit_value = v;
    tick();
    edit_en = 1'b0;
  endtask

  initial begin
    int cnt;
    int errs;
    int swaps;
    int flips;
    logic prev_fs;

    rst = 1'b1;
    {read_x, write_x, disp_x, edit_x} = '0;
    {read_y, write_y, disp_y, edit_y} = '0;
    {write_value, write_enable, edit_en, edit_value, swap_req, clear_req} = '0;
    repeat (3) tick();

    check("rst_busy", 32'(busy), 1);
    check("rst_front_sel", 32'(front_sel), 0);
    check("rst_swap_done", 32'(swap_done), 0);
    check("rst_disp_cell", 32'(disp_cell), 0);
    check("rst_population", 32'(population), 0);

    // Power-on clear length
    rst = 1'b0;
    cnt = 0;
    while (busy && cnt < 6000) begin
      cnt++;
      tick();
    end
    check("clear_len", cnt, 4800);
    check("idle_after_clear", 32'(busy), 0);

    errs = 0;
    for (int y = 0; y < 60; y++)
      for (int x = 0; x < 80; x++) begin
        read_x = 7'(x);
        read_y = 6'(y);
        #1;
        if (cell_state !== 1'b0) errs++;
      end
    check("clear_all_zero", errs, 0);
    disp_probe("disp_zero_00", 0, 0, 1'b0);
    disp_probe("disp_zero_7959", 79, 59, 1'b0);

    // User edits on the front bank
    edit(5, 7, 1'b1);
    edit(80, 7, 1'b1);
    read_chk("edit_rd_5_7", 5, 7, 1'b1);
    read_chk("edit_oob_alias_0_8", 0, 8, 1'b0);
    read_chk("rd_oob_80_7", 80, 7, 1'b0);
    disp_probe("disp_5_7", 5, 7, 1'b1);
    disp_probe("disp_4_7", 4, 7, 1'b0);
    disp_probe("disp_oob_80_7", 80, 7, 1'b0);

    // Engine writes to the back bank, then swap
    eng_write(79, 59, 1'b1);
    eng_write(80, 0, 1'b1);
    read_chk("back_not_visible", 79, 59, 1'b0);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("swap1_done", 32'(swap_done), 1);
    check("swap1_front", 32'(front_sel), 1);
    check("swap1_busy", 32'(busy), 1);
    tick();
    check("swap1_done_off", 32'(swap_done), 0);
    check("swap1_idle", 32'(busy), 0);
    read_chk("swap1_rd_79_59", 79, 59, 1'b1);
    read_chk("oob_write_alias_0_1", 0, 1, 1'b0);
    read_chk("swap1_rd_5_7", 5, 7, 1'b0);

    // Write in the swap cycle lands in the pre-swap back bank
    write_enable = 1'b1;
    write_x = 7'd10;
    write_y = 6'd10;
    write_value = 1'b1;
    swap_req = 1'b1;
    tick();
    write_enable = 1'b0;
    swap_req = 1'b0;
    check("swap2_front", 32'(front_sel), 0);
    tick();
    read_chk("swap2_rd_10_10", 10, 10, 1'b1);
    read_chk("swap2_rd_5_7", 5, 7, 1'b1);

    // Population: 3 live, 2 dead, 1 out-of-range live
    eng_write(1, 0, 1'b1);
    eng_write(2, 0, 1'b1);
    eng_write(3, 0, 1'b1);
    eng_write(4, 0, 1'b0);
    eng_write(5, 0, 1'b0);
    eng_write(80, 0, 1'b1);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("swap3_front", 32'(front_sel), 1);
    check("pop_swap", 32'(population), POP_EXP);
    tick();
    check("pop_hold", 32'(population), POP_EXP);
    read_chk("swap3_rd_2_0", 2, 0, 1'b1);
    read_chk("swap3_rd_4_0", 4, 0, 1'b0);

    // Clear with simultaneous swap, plus ignored traffic mid-clear
    clear_req = 1'b1;
    swap_req = 1'b1;
    tick();
    clear_req = 1'b0;
    swap_req = 1'b0;
    check("clr_prio_busy", 32'(busy), 1);
    check("clr_prio_no_swap", 32'(swap_done), 0);
    check("clr_prio_front", 32'(front_sel), 1);
    cnt = 0;
    swaps = 0;
    flips = 0;
    prev_fs = front_sel;
    while (busy && cnt < 10000) begin
      if (swap_done) swaps++;
      if (front_sel !== prev_fs) flips++;
      prev_fs = front_sel;
      if (cnt == 100) begin
        {edit_en, edit_value, write_enable, write_value, clear_req, swap_req} = '1;
        edit_x = 7'd0;  edit_y = 6'd0;
        write_x = 7'd0; write_y = 6'd0;
      end else begin
        {edit_en, write_enable, clear_req, swap_req} = '0;
      end
      cnt++;
      tick();
    end
    check("clr_swap_busy_len", cnt, 4801);
    check("clr_swap_pulses", swaps, 1);
    check("clr_swap_flips", flips, 1);
    check("clr_swap_front", 32'(front_sel), 0);
    check("clr_pop_zero", 32'(population), 0);
    read_chk("clr_edit_discard", 0, 0, 1'b0);
    read_chk("clr_rd_10_10", 10, 10, 1'b0);
    read_chk("clr_rd_5_7", 5, 7, 1'b0);
    disp_probe("clr_disp_0_0", 0, 0, 1'b0);

    // Reset mid-clear restarts the clear and drops the swapped bank
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    check("pre_rst_front", 32'(front_sel), 1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (2000) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_front", 32'(front_sel), 0);
    check("midrst_swap_done", 32'(swap_done), 0);
    cnt = 0;
    while (busy && cnt < 6000) begin
      cnt++;
      tick();
    end
    check("midrst_clear_len", cnt, 4800);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/grid_buffer.md
GRID_BUFFER -- requirements
Module: grid_buffer

Interface
REQ-001 SHALL have parameter GRID_W, default 80, meaning grid columns.
REQ-002 SHALL have parameter GRID_H, default 60, meaning grid rows.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports read_x/read_y  input  7/6  engine read coordinate; cell_state  output  1  front-bank cell value.
REQ-006 SHALL have ports write_x/write_y  input  7/6, write_value  input  1, write_enable  input  1  engine writes to the back bank.
REQ-007 SHALL have ports disp_x/disp_y  input  7/6, disp_cell  output  1  display read of the front bank.
REQ-008 SHALL have ports edit_en  input  1, edit_x/edit_y  input  7/6, edit_value  input  1  user edits to the front bank.
REQ-009 SHALL have ports swap_req  input  1, swap_done  output  1, clear_req  input  1, busy  output  1, front_sel  output  1, population  output  13.

Function
REQ-010 SHALL hold two banks of GRID_W*GRID_H bits; address = y*GRID_W+x; front bank = bank[front_sel], back bank = bank[~front_sel].
REQ-011 SHALL drive cell_state combinationally from the front bank at (read_x, read_y), zero-cycle latency, so the engine samples it in its wait cycle.
REQ-012 SHALL register disp_cell: value at (disp_x, disp_y) visible one cycle after the address is presented.
REQ-013 SHALL return 0 on any read with x>=GRID_W or y>=GRID_H and SHALL ignore any write or edit with such a coordinate.
REQ-014 SHALL write write_value into the back bank on a cycle where write_enable=1 and state is IDLE.
REQ-015 SHALL write edit_value into the front bank on a cycle where edit_en=1 and state is IDLE; engine write and edit in one cycle both take effect.
REQ-016 SHALL use states IDLE, CLEARING and SWAP; busy=1 in CLEARING and SWAP, 0 in IDLE.
REQ-017 IDLE + swap_req -> SWAP; SWAP toggles front_sel, pulses swap_done for exactly one cycle and returns to IDLE on the next edge (1-cycle swap latency).
REQ-018 An engine write in the same cycle as swap_req SHALL land in the pre-swap back bank.
REQ-019 IDLE + clear_req -> CLEARING; clear_req takes priority over a simultaneous swap_req, and that swap is remembered as pending.
REQ-020 CLEARING SHALL zero one address per cycle in both banks, 0 to GRID_W*GRID_H-1 (4800 cycles at default), then go to IDLE, or to SWAP if a swap is pending.
REQ-021 In CLEARING, engine writes and edits SHALL be discarded; reads SHALL return current memory contents; clear_req SHALL be ignored; swap_req SHALL set pending.
REQ-022 The clear address counter SHALL be 13 bits and SHALL not wrap past the last address.

Reset
REQ-023 On rst: front_sel=0, swap_done=0, disp_cell=0, population=0, pending swap cleared, clear counter=0, state=CLEARING (busy=1 next cycle).
REQ-024 Reset asserted mid-clear or mid-swap SHALL restart the clear from address 0 and abandon the swap (front_sel=0).

Configuration
REQ-025 With POPULATION_COUNT_EN defined: a 13-bit counter SHALL count accepted back-bank writes with write_value=1, latch into population in the SWAP cycle, then restart from 0; clearing SHALL zero both counter and population.
REQ-026 Without POPULATION_COUNT_EN: population SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-027 Reset, run 4801 cycles -> busy=1 for exactly 4800 cycles, then 0; every cell_state and disp_cell read returns 0.
REQ-028 Edit (5,7)=1 in IDLE -> cell_state=1 at read (5,7) same cycle; disp_cell=1 one cycle after disp (5,7).
REQ-029 Engine write (79,59)=1 then swap_req -> swap_done pulses once, front_sel=1, cell_state at (79,59)=1; a write to (80,0) leaves memory unchanged.
REQ-030 swap_req during CLEARING -> no toggle until clear ends, then a single swap_done and front_sel flips once.
REQ-031 POPULATION_COUNT_EN: write 3 live and 2 dead cells, swap -> population=3; without the macro -> population=0.
REQ-032 rst at clear address 2000 -> clear restarts at 0, busy stays 1 for 4800 further cycles.
